// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding instruction fetch, with a hold buffer for
// load-use stalls and squashing of responses that arrive after a redirect.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        RVPCSrcE,
    input  logic        BranchTakenE,
    input  logic        PCSrcW,
    input  logic        PCWrPendingF,
    input  logic        StallReqD,
    output logic        imem_req,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic        redirect;
    logic        stall_req;
    logic        deliver;

    // Hazard inputs are masked while in reset so outputs sit at reset values.
    assign redirect  = rst & (arm ? (BranchTakenE | PCSrcW) : RVPCSrcE);
    assign stall_req = rst & StallReqD;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        deliver  = 1'b0;
        InstrF   = 32'h0;
        imem_req = 1'b0;
        unique case (state_q)
            S_REQ: begin
                imem_req = rst & ~(arm & PCWrPendingF);
                if (imem_req & imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (stall_req) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        InstrF  = imem_rdata;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!stall_req) begin
                    deliver = 1'b1;
                    InstrF  = buf_q;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    assign StallF = ~(deliver | redirect);
    assign StallD = stall_req & ~redirect;
    assign FlushD = redirect | (~StallD & ~deliver);
    assign FlushE = redirect | stall_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        RVPCSrcE;
    logic        BranchTakenE;
    logic        PCSrcW;
    logic        PCWrPendingF;
    logic        StallReqD;
    logic        imem_req;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;

    int n_chk = 0;
    int n_fail = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .arm(arm),
        .RVPCSrcE(RVPCSrcE), .BranchTakenE(BranchTakenE),
        .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF),
        .StallReqD(StallReqD), .imem_req(imem_req),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .InstrF(InstrF),
        .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE)
    );

    always #5 clk = ~clk;

    // Reference model: a fetch is either awaited (busy), doomed (kill),
    // or its instruction is parked in a one-entry buffer (have).
    bit          m_busy, m_kill, m_have;
    logic [31:0] m_buf;
    logic        e_req, e_stf, e_std, e_fd, e_fe, e_del, e_redir, e_stall;
    logic [31:0] e_instr;

    function automatic void model_eval();
        if (!rst) begin
            m_busy = 0; m_kill = 0; m_have = 0; m_buf = 0;
        end
        e_redir = rst && (arm ? (BranchTakenE || PCSrcW) : RVPCSrcE);
        e_stall = rst && StallReqD;
        e_del   = 0;
        e_instr = 0;
        if (m_have) begin
            if (!e_stall && !e_redir) begin
                e_del = 1; e_instr = m_buf;
            end
        end else if (m_busy && !m_kill && imem_rvalid && !e_redir && !e_stall) begin
            e_del = 1; e_instr = imem_rdata;
        end
        e_req = rst && !m_busy && !m_have && !(arm && PCWrPendingF);
        e_std = e_stall && !e_redir;
        e_stf = !(e_del || e_redir);
        e_fd  = e_redir || (!e_std && !e_del);
        e_fe  = e_redir || e_stall;
    endfunction

    function automatic void model_next();
        model_eval();
        if (!rst) begin
            m_busy = 0; m_kill = 0; m_have = 0; m_buf = 0;
        end else if (m_have) begin
            if (e_redir || !e_stall) m_have = 0;
        end else if (m_busy) begin
            if (imem_rvalid) begin
                if (!m_kill && !e_redir && e_stall) begin
                    m_have = 1; m_buf = imem_rdata;
                end
                m_busy = 0; m_kill = 0;
            end else if (e_redir) begin
                m_kill = 1;
            end
        end else if (e_req && imem_gnt) begin
            m_busy = 1;
        end
    endfunction

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic adv();
        model_next();
        @(negedge clk);
    endtask

    task automatic quiet();
        RVPCSrcE = 0; BranchTakenE = 0; PCSrcW = 0;
        PCWrPendingF = 0; StallReqD = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        RVPCSrcE = 1; StallReqD = 1; imem_rvalid = 1; imem_gnt = 1;
        imem_rdata = 32'h1234_5678;
        settle();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_req); end
        n_chk++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL rst_stallf got %b exp 1", StallF); end
        n_chk++; if (StallD !== 1'b0) begin n_fail++; $display("FAIL rst_stalld got %b exp 0", StallD); end
        n_chk++; if (FlushD !== 1'b1) begin n_fail++; $display("FAIL rst_flushd got %b exp 1", FlushD); end
        n_chk++; if (FlushE !== 1'b0) begin n_fail++; $display("FAIL rst_flushe got %b exp 0", FlushE); end
        n_chk++; if (InstrF !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", InstrF); end
        adv();
        quiet();
        rst = 1;
        settle();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", imem_req); end
        imem_gnt = 1;
        adv();
    endtask

    task automatic test_back_to_back();
        int ndel = 0;
        for (int i = 0; i < 3; i++) begin
            quiet();
            imem_rvalid = 1; imem_rdata = 32'h0000_0013;
            settle();
            if (InstrF === 32'h13 && StallF === 1'b0) ndel++;
            n_chk++; if (InstrF !== 32'h13) begin n_fail++; $display("FAIL b2b_instr got %h exp 00000013", InstrF); end
            n_chk++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL b2b_stallf got %b exp 0", StallF); end
            n_chk++; if (FlushD !== 1'b0) begin n_fail++; $display("FAIL b2b_flushd got %b exp 0", FlushD); end
            adv();
            quiet();
            settle();
            n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req got %b exp 1", imem_req); end
            n_chk++; if (InstrF !== 32'h0) begin n_fail++; $display("FAIL b2b_idle got %h exp 0", InstrF); end
            imem_gnt = 1;
            adv();
        end
        n_chk++; if (ndel != 3) begin n_fail++; $display("FAIL b2b_rate got %0d exp 3", ndel); end
    endtask

    task automatic test_load_use();
        quiet();
        imem_rvalid = 1; imem_rdata = 32'hE3A0_1005; StallReqD = 1;
        settle();
        n_chk++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL lu_stalld got %b exp 1", StallD); end
        n_chk++; if (FlushE !== 1'b1) begin n_fail++; $display("FAIL lu_flushe got %b exp 1", FlushE); end
        n_chk++; if (InstrF !== 32'h0) begin n_fail++; $display("FAIL lu_instr got %h exp 0", InstrF); end
        n_chk++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL lu_stallf got %b exp 1", StallF); end
        adv();
        imem_rvalid = 0; imem_rdata = 32'hFFFF_FFFF;
        settle();
        n_chk++; if (StallD !== 1'b1) begin n_fail++; $display("FAIL hold_stalld got %b exp 1", StallD); end
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req got %b exp 0", imem_req); end
        adv();
        StallReqD = 0;
        settle();
        n_chk++; if (InstrF !== 32'hE3A0_1005) begin n_fail++; $display("FAIL hold_instr got %h exp e3a01005", InstrF); end
        n_chk++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL hold_stallf got %b exp 0", StallF); end
        n_chk++; if (FlushD !== 1'b0) begin n_fail++; $display("FAIL hold_flushd got %b exp 0", FlushD); end
        adv();
        quiet();
        imem_gnt = 1;
        settle();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL lu_rereq got %b exp 1", imem_req); end
        adv();
    endtask

    task automatic test_rv_branch();
        quiet();
        RVPCSrcE = 1;
        settle();
        n_chk++; if (FlushD !== 1'b1) begin n_fail++; $display("FAIL rvb_flushd got %b exp 1", FlushD); end
        n_chk++; if (FlushE !== 1'b1) begin n_fail++; $display("FAIL rvb_flushe got %b exp 1", FlushE); end
        n_chk++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL rvb_stallf got %b exp 0", StallF); end
        adv();
        RVPCSrcE = 0;
        settle();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drop_req got %b exp 0", imem_req); end
        adv();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        settle();
        n_chk++; if (InstrF !== 32'h0) begin n_fail++; $display("FAIL drop_instr got %h exp 0", InstrF); end
        n_chk++; if (FlushD !== 1'b1) begin n_fail++; $display("FAIL drop_flushd got %b exp 1", FlushD); end
        n_chk++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL drop_stallf got %b exp 1", StallF); end
        adv();
        quiet();
        imem_gnt = 1;
        settle();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rvb_target_req got %b exp 1", imem_req); end
        adv();
    endtask

    task automatic test_arm_pcsrcw();
        quiet();
        arm = 1; PCSrcW = 1; imem_rvalid = 1; imem_rdata = 32'hE12F_FF1E;
        settle();
        n_chk++; if (InstrF !== 32'h0) begin n_fail++; $display("FAIL armw_instr got %h exp 0", InstrF); end
        n_chk++; if (FlushD !== 1'b1) begin n_fail++; $display("FAIL armw_flushd got %b exp 1", FlushD); end
        n_chk++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL armw_stallf got %b exp 0", StallF); end
        adv();
        quiet();
        settle();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL armw_req got %b exp 1", imem_req); end
    endtask

    task automatic test_arm_pending();
        quiet();
        PCWrPendingF = 1; imem_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL pend_req got %b exp 0", imem_req); end
            n_chk++; if (FlushD !== 1'b1) begin n_fail++; $display("FAIL pend_flushd got %b exp 1", FlushD); end
            n_chk++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL pend_stallf got %b exp 1", StallF); end
            adv();
        end
        PCWrPendingF = 0;
        settle();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL pend_resume got %b exp 1", imem_req); end
        adv();
        imem_gnt = 0;
        settle();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL pend_wait got %b exp 0", imem_req); end
        arm = 0;
    endtask

    task automatic test_reset_in_wait();
        quiet();
        rst = 0;
        settle();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_req got %b exp 0", imem_req); end
        n_chk++; if (FlushD !== 1'b1 || StallF !== 1'b1) begin n_fail++; $display("FAIL rw_flushd_stallf got %b%b exp 11", FlushD, StallF); end
        adv();
        rst = 1; imem_rvalid = 1; imem_rdata = 32'h0BAD_0BAD;
        settle();
        n_chk++; if (InstrF !== 32'h0) begin n_fail++; $display("FAIL rw_stale got %h exp 0", InstrF); end
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req2 got %b exp 1", imem_req); end
        adv();
        imem_rvalid = 0;
        settle();
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_stay got %b exp 1", imem_req); end
        adv();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 79) != 0);
            arm          = $urandom_range(0, 1) == 1;
            RVPCSrcE     = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 9) == 0);
            PCSrcW       = ($urandom_range(0, 15) == 0);
            PCWrPendingF = ($urandom_range(0, 3) == 0);
            StallReqD    = ($urandom_range(0, 3) == 0);
            imem_gnt     = $urandom_range(0, 1) == 1;
            imem_rvalid  = m_busy && ($urandom_range(0, 1) == 1);
            imem_rdata   = $urandom;
            settle();
            n_chk++; if (imem_req !== e_req) begin n_fail++; $display("FAIL rnd_req @%0d got %b exp %b", i, imem_req, e_req); end
            n_chk++; if (InstrF !== e_instr) begin n_fail++; $display("FAIL rnd_instr @%0d got %h exp %h", i, InstrF, e_instr); end
            n_chk++; if (StallF !== e_stf) begin n_fail++; $display("FAIL rnd_stallf @%0d got %b exp %b", i, StallF, e_stf); end
            n_chk++; if (StallD !== e_std) begin n_fail++; $display("FAIL rnd_stalld @%0d got %b exp %b", i, StallD, e_std); end
            n_chk++; if (FlushD !== e_fd) begin n_fail++; $display("FAIL rnd_flushd @%0d got %b exp %b", i, FlushD, e_fd); end
            n_chk++; if (FlushE !== e_fe) begin n_fail++; $display("FAIL rnd_flushe @%0d got %b exp %b", i, FlushE, e_fe); end
            adv();
        end
    endtask

    initial begin
        rst = 0; arm = 0;
        quiet();
        m_busy = 0; m_kill = 0; m_have = 0; m_buf = 0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_load_use();
        test_rv_branch();
        test_arm_pcsrcw();
        adv();
        test_arm_pending();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state changes on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-003 arm  in  1  ISA select: 1=ARM, 0=RISC-V.
REQ-004 RVPCSrcE  in  1  RISC-V taken branch/jump in E.
REQ-005 BranchTakenE  in  1  ARM taken branch in E.
REQ-006 PCSrcW  in  1  ARM write to PC retiring in W.
REQ-007 PCWrPendingF  in  1  ARM PC write in flight in D/E/M.
REQ-008 StallReqD  in  1  load-use stall request from hazard logic.
REQ-009 imem_req  out  1  instruction fetch request (PC taken from PCF).
REQ-010 imem_gnt  in  1  request accepted this cycle.
REQ-011 imem_rvalid  in  1  response valid; at least 1 cycle after the accepting gnt.
REQ-012 imem_rdata  in  32  response instruction.
REQ-013 InstrF  out  32  instruction presented to the D register (RDD).
REQ-014 StallF  out  1  hold PCF.
REQ-015 StallD  out  1  hold D register.
REQ-016 FlushD  out  1  load bubble into D.
REQ-017 FlushE  out  1  load bubble into E.

Function
REQ-018 redirect = arm ? (BranchTakenE | PCSrcW) : RVPCSrcE.
REQ-019 At most one fetch outstanding; states REQ, WAIT, HOLD, DROP; 32-bit hold buffer.
REQ-020 REQ: imem_req = !(arm & PCWrPendingF); on imem_req & imem_gnt -> WAIT, else stay.
REQ-021 WAIT: rvalid & !redirect & !StallReqD -> deliver imem_rdata, -> REQ.
REQ-022 WAIT: rvalid & StallReqD & !redirect -> capture imem_rdata in buffer, -> HOLD.
REQ-023 WAIT: redirect & !rvalid -> DROP; redirect & rvalid -> discard data, -> REQ.
REQ-024 HOLD: !StallReqD & !redirect -> deliver buffer, -> REQ; redirect -> discard buffer, -> REQ.
REQ-025 DROP: rvalid -> discard, -> REQ; redirect in DROP stays DROP (PC redirect still taken).
REQ-026 deliver: InstrF = imem_rdata in WAIT, buffer in HOLD; InstrF = 0 when not delivering.
REQ-027 StallF = !(deliver | redirect); a redirect always lets stage_f load the target PC.
REQ-028 StallD = StallReqD & !redirect; redirect has priority over load-use stall.
REQ-029 FlushD = redirect | (!StallD & !deliver); FlushE = redirect | StallReqD.
REQ-030 ARM with PCWrPendingF=1 in REQ: no request, StallF=1, FlushD=1 until cleared.
REQ-031 imem_gnt ignored outside REQ; imem_rvalid ignored in REQ and HOLD.
REQ-032 Outputs combinational from state and inputs; zero-cycle decision latency.

Reset
REQ-033 rst=0 forces state REQ, buffer 0, asynchronously.
REQ-034 During reset: imem_req=0, StallF=1, StallD=0, FlushD=1, FlushE=0, InstrF=0.
REQ-035 First request issued on the first rising edge after rst deasserts.
REQ-036 Reset mid-fetch abandons the outstanding request; the first imem_rvalid after reset in REQ is ignored.

Verification
REQ-037 Back-to-back: gnt immediate, rvalid 1 cycle later, rdata 0x00000013 -> delivered, StallF=0 that cycle, one instruction per 2 cycles.
REQ-038 Load-use: StallReqD=1 when rdata 0xE3A01005 returns -> HOLD, StallD=1, FlushE=1; StallReqD drops -> InstrF=0xE3A01005, StallF=0.
REQ-039 RISC-V branch: RVPCSrcE=1 in WAIT, rvalid 2 cycles later -> DROP, response discarded, FlushD=1, FlushE=1, next request from target 0x1000.
REQ-040 ARM: arm=1, PCSrcW=1 simultaneous with rvalid -> data discarded, FlushD=1, StallF=0, -> REQ.
REQ-041 ARM PCWrPendingF=1 for 3 cycles -> imem_req=0 and FlushD=1 those cycles, request resumes next cycle.
REQ-042 Assert rst=0 in WAIT -> outputs reach reset values immediately, stale rvalid ignored.
